// File: rtl/pulse_updown_cnt.sv
// pulse_updown_cnt
//   Modulo-MODULUS up/down counter for the watch time fields (sec/min/hr).
//   Keeps a binary count and a BCD tens/ones copy in lock-step, so the digits
//   can feed the 7-segment mux without a binary-to-BCD converter.
// Ports
//   clock      system clock, all state changes on posedge
//   reset      synchronous, active-high
//   enable     gates inc_pulse/dec_pulse (load is not gated)
//   inc_pulse  one-cycle step-up request
//   dec_pulse  one-cycle step-down request
//   load       one-cycle preset request, value on load_data
//   load_data  preset value (binary)
//   data       current count, binary
//   bcd_tens   tens digit of data
//   bcd_ones   ones digit of data
//   carry      one-cycle strobe on wrap MODULUS-1 -> 0
//   borrow     one-cycle strobe on wrap 0 -> MODULUS-1
//   load_err   one-cycle strobe when load_data >= MODULUS (load rejected)
module pulse_updown_cnt #(
  parameter int WIDTH       = 6,
  parameter int MODULUS     = 60,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             inc_pulse,
  input  logic             dec_pulse,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             carry,
  output logic             borrow,
  output logic             load_err
);

  localparam int MAX = MODULUS - 1;
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [3:0] MAX_T = 4'(MAX / 10);
  localparam logic [3:0] MAX_O = 4'(MAX % 10);
  localparam logic [3:0] RST_T = 4'(RESET_VALUE / 10);
  localparam logic [3:0] RST_O = 4'(RESET_VALUE % 10);

  typedef struct packed {
    logic up;
    logic dn;
  } step_t;

  step_t            step;
  logic             ld_ok;
  logic [3:0]       ld_tens, ld_ones;
  logic [WIDTH-1:0] data_n;
  logic [3:0]       tens_n, ones_n;
  logic             carry_n, borrow_n, err_n;

  // inc and dec together cancel: no step, no strobe.
  assign step.up = enable & inc_pulse & ~dec_pulse;
  assign step.dn = enable & dec_pulse & ~inc_pulse;

  assign ld_ok   = 32'(load_data) < MODULUS;
  // Only consumed when ld_ok, so the value is < 100 and fits two digits.
  assign ld_tens = 4'(32'(load_data) / 10);
  assign ld_ones = 4'(32'(load_data) % 10);

  always_comb begin
    data_n   = data;
    tens_n   = bcd_tens;
    ones_n   = bcd_ones;
    carry_n  = 1'b0;
    borrow_n = 1'b0;
    err_n    = 1'b0;
    if (load) begin
      // A load, accepted or not, swallows any step in the same cycle.
      if (ld_ok) begin
        data_n = load_data;
        tens_n = ld_tens;
        ones_n = ld_ones;
      end else begin
        err_n  = 1'b1;
      end
    end else if (step.up) begin
      if (data == MAX_W) begin
        data_n  = '0;
        tens_n  = 4'd0;
        ones_n  = 4'd0;
        carry_n = 1'b1;
      end else begin
        data_n = data + ONE_W;
        if (bcd_ones == 4'd9) begin
          ones_n = 4'd0;
          tens_n = bcd_tens + 4'd1;
        end else begin
          ones_n = bcd_ones + 4'd1;
        end
      end
    end else if (step.dn) begin
      if (data == '0) begin
        data_n   = MAX_W;
        tens_n   = MAX_T;
        ones_n   = MAX_O;
        borrow_n = 1'b1;
      end else begin
        data_n = data - ONE_W;
        if (bcd_ones == 4'd0) begin
          ones_n = 4'd9;
          tens_n = bcd_tens - 4'd1;
        end else begin
          ones_n = bcd_ones - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data     <= RST_W;
      bcd_tens <= RST_T;
      bcd_ones <= RST_O;
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      data     <= data_n;
      bcd_tens <= tens_n;
      bcd_ones <= ones_n;
      carry    <= carry_n;
      borrow   <= borrow_n;
      load_err <= err_n;
    end
  end

endmodule

// File: tb/tb_pulse_updown_cnt.sv
module tb_pulse_updown_cnt;

  logic       clock = 1'b0;
  logic       reset, enable, inc_pulse, dec_pulse, load;
  logic [5:0] load_data;

  logic [5:0] data;
  logic [3:0] bcd_tens, bcd_ones;
  logic       carry, borrow, load_err;

  logic [4:0] data2;
  logic [3:0] tens2, ones2;
  logic       carry2, borrow2, err2;

  int n_chk  = 0;
  int n_fail = 0;
  bit inv_on = 1'b0;

  always #5 clock = ~clock;

  pulse_updown_cnt #(.WIDTH(6), .MODULUS(60), .RESET_VALUE(0)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .load(load), .load_data(load_data),
    .data(data), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .carry(carry), .borrow(borrow), .load_err(load_err)
  );

  pulse_updown_cnt #(.WIDTH(5), .MODULUS(24), .RESET_VALUE(12)) u_dut2 (
    .clock(clock), .reset(reset), .enable(enable), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .load(load), .load_data(load_data[4:0]),
    .data(data2), .bcd_tens(tens2), .bcd_ones(ones2),
    .carry(carry2), .borrow(borrow2), .load_err(err2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Binary and BCD copies must agree on every cycle, in both configurations.
  always @(negedge clock) begin
    if (inv_on) begin
      chk("inv60", int'(data), 10 * int'(bcd_tens) + int'(bcd_ones));
      chk("inv24", int'(data2), 10 * int'(tens2) + int'(ones2));
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; inc_pulse = 1'b1; dec_pulse = 1'b0;
    load = 1'b0; load_data = '0;

    // 1: reset held 3 cycles with inc_pulse high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_data", int'(data), 0);
      chk("rst_tens", int'(bcd_tens), 0);
      chk("rst_ones", int'(bcd_ones), 0);
      chk("rst_strb", int'({carry, borrow, load_err}), 0);
    end
    chk("rst_data2", int'(data2), 12);
    inv_on = 1'b1;

    // 2: inc held for 60 cycles -> 1..59 then 0 with carry
    reset = 1'b0; inc_pulse = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      chk("up_data", int'(data), i % 60);
      chk("up_carry", int'(carry), (i == 60) ? 1 : 0);
      if (i == 9)  chk("up_9",  int'({bcd_tens, bcd_ones}), 'h09);
      if (i == 10) chk("up_10", int'({bcd_tens, bcd_ones}), 'h10);
      if (i == 59) chk("up_59", int'({bcd_tens, bcd_ones}), 'h59);
      if (i == 60) chk("up_0",  int'({bcd_tens, bcd_ones}), 'h00);
    end
    inc_pulse = 1'b0;
    tick();
    chk("carry_drop", int'(carry), 0);
    chk("hold_data", int'(data), 0);

    // 3: down wrap 0 -> 59 with borrow, then 58
    dec_pulse = 1'b1;
    tick();
    chk("dn_data", int'(data), 59);
    chk("dn_bcd", int'({bcd_tens, bcd_ones}), 'h59);
    chk("dn_borrow", int'(borrow), 1);
    tick();
    chk("dn_data2", int'(data), 58);
    chk("dn_borrow2", int'(borrow), 0);
    dec_pulse = 1'b0;

    // 4: enable low freezes the count; inc&dec together holds
    enable = 1'b0; inc_pulse = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gate_data", int'(data), 58);
      chk("gate_strb", int'({carry, borrow}), 0);
    end
    enable = 1'b1; dec_pulse = 1'b1;
    tick();
    tick();
    chk("both_data", int'(data), 58);
    chk("both_strb", int'({carry, borrow}), 0);
    dec_pulse = 1'b0;

    // 5: load 42 overrides inc; load 60 rejected
    load = 1'b1; load_data = 6'd42;
    tick();
    chk("ld_data", int'(data), 42);
    chk("ld_bcd", int'({bcd_tens, bcd_ones}), 'h42);
    chk("ld_carry", int'(carry), 0);
    chk("ld_err0", int'(load_err), 0);
    load_data = 6'd60;
    tick();
    chk("lderr_data", int'(data), 42);
    chk("lderr_bcd", int'({bcd_tens, bcd_ones}), 'h42);
    chk("lderr_strb", int'(load_err), 1);
    load = 1'b0; inc_pulse = 1'b0;
    tick();
    chk("lderr_drop", int'(load_err), 0);
    chk("lderr_hold", int'(data), 42);

    // reset beats a simultaneous load
    reset = 1'b1; load = 1'b1; load_data = 6'd33;
    tick();
    chk("rst_over_ld", int'(data), 0);
    chk("rst_over_ld2", int'(data2), 12);

    // 6: mod-24 instance from 12: 12 incs -> 0 with carry, dec -> 23 borrow
    reset = 1'b0; load = 1'b0; inc_pulse = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("m24_data", int'(data2), (12 + i) % 24);
      chk("m24_carry", int'(carry2), (i == 12) ? 1 : 0);
    end
    chk("m24_bcd0", int'({tens2, ones2}), 'h00);
    inc_pulse = 1'b0; dec_pulse = 1'b1;
    tick();
    chk("m24_dn", int'(data2), 23);
    chk("m24_dnbcd", int'({tens2, ones2}), 'h23);
    chk("m24_borrow", int'(borrow2), 1);
    chk("m24_carry0", int'(carry2), 0);
    dec_pulse = 1'b0;
    tick();
    chk("m24_brdrop", int'(borrow2), 0);
    chk("m60_after", int'(data), 11);

    @(negedge clock);
    inv_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
